arm_pc_imm_unit: RTL and testbench

//  Program-counter and immediate-generation slice of the single-cycle ARMv4 datapath.
//  - Holds the PC register and selects the next PC.
//  - Produces PC+4 (sequential fetch) and PC+8 (architectural R15 read value).
//  - Extends the instruction immediate field to 32 bits for the ALU SrcB mux and for branches.
//  - Sits between the control unit and the instruction memory / register file.

---
 rtl/arm_pc_imm_unit.sv | 67 ++++++
 tb/tb_arm_pc_imm_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/arm_pc_imm_unit.sv
// PC register, PC+4 / PC+8 adders and immediate extender for the single-cycle ARMv4 datapath.
// The PC updates on every rising edge; the adders and the extender are purely combinational.
module arm_pc_imm_unit #(
   parameter int unsigned      WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             PCSrc,
   input  logic [WIDTH-1:0] Result,
   input  logic [1:0]       ImmSrc,
   input  logic [23:0]      Imm24,
   output logic [WIDTH-1:0] PC_out,
   output logic [WIDTH-1:0] PCPLUS4,
   output logic [WIDTH-1:0] PCPLUS8,
   output logic [WIDTH-1:0] ExtImm
);

   localparam logic [WIDTH-1:0] Four = WIDTH'(4);

   // Power-up value matches the reset value so the PC is defined before the first edge.
   logic [WIDTH-1:0] pc_q = RESET_PC;
   logic [WIDTH-1:0] pc_d;

   logic [WIDTH-1:0] pc_plus4;
   logic [WIDTH-1:0] pc_plus8;

   // Adders wrap modulo 2^WIDTH; the carry out is deliberately discarded.
   always_comb begin
      pc_plus4 = pc_q + Four;
      pc_plus8 = pc_plus4 + Four;
   end

   // Result is loaded unmodified, including unaligned values.
   always_comb begin
      pc_d = pc_plus4;
      if (PCSrc) begin
         pc_d = Result;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   logic signed [25:0] branch_off;

   always_comb begin
      branch_off = $signed({Imm24, 2'b00});
      ExtImm     = '0;
      unique case (ImmSrc)
         2'b00:   ExtImm = WIDTH'(Imm24[7:0]);
         2'b01:   ExtImm = WIDTH'(Imm24[11:0]);
         2'b10:   ExtImm = WIDTH'(branch_off);
         default: ExtImm = '0;
      endcase
   end

   assign PC_out  = pc_q;
   assign PCPLUS4 = pc_plus4;
   assign PCPLUS8 = pc_plus8;

endmodule

// File: tb/tb_arm_pc_imm_unit.sv
// Self-checking bench for arm_pc_imm_unit: directed steps followed by randomized traffic,
// compared against an arithmetic reference model of the PC and the immediate formats.
module tb_arm_pc_imm_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        PCSrc;
   logic [31:0] Result;
   logic [1:0]  ImmSrc;
   logic [23:0] Imm24;
   logic [31:0] PC_out;
   logic [31:0] PCPLUS4;
   logic [31:0] PCPLUS8;
   logic [31:0] ExtImm;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_pc;

   always #5 clk = ~clk;

   arm_pc_imm_unit #(
      .WIDTH    (32),
      .RESET_PC (32'h0)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .PCSrc   (PCSrc),
      .Result  (Result),
      .ImmSrc  (ImmSrc),
      .Imm24   (Imm24),
      .PC_out  (PC_out),
      .PCPLUS4 (PCPLUS4),
      .PCPLUS8 (PCPLUS8),
      .ExtImm  (ExtImm)
   );

   // Reference immediate: computed from the format rules with plain arithmetic.
   function automatic logic [31:0] ref_ext(input logic [1:0] src, input logic [23:0] imm);
      logic [31:0] v;
      case (src)
         2'd0: v = 32'(imm) % 32'd256;
         2'd1: v = 32'(imm) % 32'd4096;
         2'd2: begin
            v = 32'(imm) * 32'd4;
            if (32'(imm) >= 32'h0080_0000) v = v + 32'hFC00_0000;
         end
         default: v = 32'd0;
      endcase
      return v;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask

   task automatic check_pc(input string tag);
      check({tag, ".pc"}, PC_out, exp_pc);
      check({tag, ".pc4"}, PCPLUS4, exp_pc + 32'd4);
      check({tag, ".pc8"}, PCPLUS8, exp_pc + 32'd8);
   endtask

   // Advance one edge; the model's next PC is taken from the inputs present at the edge.
   task automatic tick();
      logic [31:0] nxt;
      if (reset) nxt = 32'h0;
      else if (PCSrc) nxt = Result;
      else nxt = exp_pc + 32'd4;
      @(posedge clk);
      #1;
      exp_pc = nxt;
   endtask

   initial begin
      reset  = 1'b1;
      PCSrc  = 1'b1;
      Result = 32'h1234;
      ImmSrc = 2'b00;
      Imm24  = 24'h0;
      exp_pc = 32'h0;
      #1;
      check("init.pc", PC_out, 32'h0);

      // Reset with a competing PC write
      tick();
      tick();
      check_pc("reset");
      check("reset.pc4_const", PCPLUS4, 32'h4);
      check("reset.pc8_const", PCPLUS8, 32'h8);

      // Sequential fetch
      reset = 1'b0;
      PCSrc = 1'b0;
      tick();
      check("seq.pc_4", PC_out, 32'h4);
      tick();
      check("seq.pc_8", PC_out, 32'h8);
      // Branch from PC=8
      PCSrc  = 1'b1;
      Result = 32'h100;
      tick();
      check("br.pc", PC_out, 32'h100);
      check("br.pc4", PCPLUS4, 32'h104);
      PCSrc = 1'b0;
      tick();
      check("br.after", PC_out, 32'h104);
      tick();
      tick();
      check_pc("seq.model");

      // Wrap-around
      PCSrc  = 1'b1;
      Result = 32'hFFFF_FFFC;
      tick();
      check("wrap.pc", PC_out, 32'hFFFF_FFFC);
      check("wrap.pc4", PCPLUS4, 32'h0);
      check("wrap.pc8", PCPLUS8, 32'h4);
      PCSrc = 1'b0;
      tick();
      check("wrap.next", PC_out, 32'h0);

      // Unaligned write is loaded as-is
      PCSrc  = 1'b1;
      Result = 32'h0000_0123;
      tick();
      check_pc("unaligned");

      // Extender
      Imm24  = 24'hABCDEF;
      ImmSrc = 2'b00; #1; check("ext.00", ExtImm, 32'h0000_00EF);
      ImmSrc = 2'b01; #1; check("ext.01", ExtImm, 32'h0000_0DEF);
      ImmSrc = 2'b10; #1; check("ext.10", ExtImm, 32'hFEAF_37BC);
      ImmSrc = 2'b11; #1; check("ext.11", ExtImm, 32'h0000_0000);
      Imm24  = 24'h000001;
      ImmSrc = 2'b10; #1; check("ext.10pos", ExtImm, 32'h0000_0004);

      // Mid-run reset
      PCSrc  = 1'b1;
      Result = 32'h40;
      tick();
      check("mid.pc40", PC_out, 32'h40);
      PCSrc = 1'b0;
      reset = 1'b1;
      #1;
      check("mid.held", PC_out, 32'h40);
      tick();
      check("mid.rst", PC_out, 32'h0);
      reset = 1'b0;
      tick();
      check("mid.rel", PC_out, 32'h4);

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         reset  = ($urandom_range(0, 15) == 0);
         PCSrc  = 1'($urandom_range(0, 1));
         Result = $urandom;
         if ($urandom_range(0, 7) == 0) Result = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
         ImmSrc = 2'($urandom_range(0, 3));
         Imm24  = 24'($urandom);
         #1;
         check("rnd.ext", ExtImm, ref_ext(ImmSrc, Imm24));
         tick();
         check_pc("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
